// File: rtl/prbs_checker.sv
// Self-synchronising PN checker for the x^7+x^6+1 parallel generator. It locks onto the stream,
// then counts bit and word errors. Define PRBS_CHK_INVERT_EN to check a bitwise-inverted stream.
module prbs_checker #(
  parameter int unsigned      POL_W      = 7,
  parameter logic [POL_W:0]   POL_MASK   = 8'hC0,
  parameter int unsigned      DW         = 16,
  parameter int unsigned      LOCK_CNT   = 4,
  parameter int unsigned      UNLOCK_CNT = 4,
  parameter int unsigned      CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             data_valid,
  input  logic [DW-1:0]    data_in,
  output logic             locked,
  output logic             err_word,
  output logic             err_sticky,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned NB_W  = $clog2(DW + 1);
  localparam int unsigned LC_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned UC_W  = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SUM_W = ((CNT_W > NB_W) ? CNT_W : NB_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e             state_q, state_d;
  logic [POL_W-1:0]   s_q, s_d;
  logic [LC_W-1:0]    lock_ctr_q, lock_ctr_d;
  logic [UC_W-1:0]    unlock_ctr_q, unlock_ctr_d;
  logic               err_word_q, err_word_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   bit_err_q, bit_err_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic [DW-1:0]      din;
  logic [DW-1:0]      exp_w;
  logic [DW-1:0]      mism;
  logic [NB_W-1:0]    nbits;

  // Expected word continues the recurrence from the POL_W most recent bits held in s.
  function automatic logic [DW-1:0] exp_word(input logic [POL_W-1:0] s);
    logic [POL_W+DW-1:0] full;
    full = '0;
    full[POL_W+DW-1 -: POL_W] = s;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      full[i] = ^(full[i +: POL_W+1] & POL_MASK);
    end
    return full[DW-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NB_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

`ifdef PRBS_CHK_INVERT_EN
  assign din = ~data_in;
`else
  assign din = data_in;
`endif

  assign exp_w = exp_word(s_q);
  assign mism  = din ^ exp_w;

  always_comb begin
    nbits = '0;
    for (int i = 0; i < int'(DW); i++) begin
      nbits = nbits + NB_W'(mism[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    lock_ctr_d   = lock_ctr_q;
    unlock_ctr_d = unlock_ctr_q;
    err_word_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    bit_err_d    = bit_err_q;
    word_cnt_d   = word_cnt_q;

    if (data_valid) begin
      unique case (state_q)
        StSearch: begin
          s_d = din[POL_W-1:0];
          if ((mism == '0) && (s_q != '0)) begin
            if (32'(lock_ctr_q) + 32'd1 == LOCK_CNT) begin
              state_d      = StLocked;
              lock_ctr_d   = '0;
              unlock_ctr_d = '0;
            end else begin
              lock_ctr_d = lock_ctr_q + LC_W'(1);
            end
          end else begin
            lock_ctr_d = '0;
          end
        end
        StLocked: begin
          // Free-running replica so a single line error is not multiplied by reseeding.
          s_d        = exp_w[POL_W-1:0];
          word_cnt_d = sat_add(word_cnt_q, NB_W'(1));
          bit_err_d  = sat_add(bit_err_q, nbits);
          if (nbits != '0) begin
            err_word_d   = 1'b1;
            err_sticky_d = 1'b1;
            if (32'(unlock_ctr_q) + 32'd1 == UNLOCK_CNT) begin
              state_d      = StSearch;
              unlock_ctr_d = '0;
              lock_ctr_d   = '0;
              s_d          = din[POL_W-1:0];
            end else begin
              unlock_ctr_d = unlock_ctr_q + UC_W'(1);
            end
          end else begin
            unlock_ctr_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (clear) begin
      err_sticky_d = 1'b0;
      bit_err_d    = '0;
      word_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSearch;
      s_q          <= '0;
      lock_ctr_q   <= '0;
      unlock_ctr_q <= '0;
      err_word_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      bit_err_q    <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      lock_ctr_q   <= lock_ctr_d;
      unlock_ctr_q <= unlock_ctr_d;
      err_word_q   <= err_word_d;
      err_sticky_q <= err_sticky_d;
      bit_err_q    <= bit_err_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign err_word    = err_word_q;
  assign err_sticky  = err_sticky_q;
  assign bit_err_cnt = bit_err_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the parallel PN generator (mask 8'hC0, i.e. x^7+x^6+1, DW bits per word).
- Accepts DW-bit words from a link or loopback path and self-synchronises to the sequence.
- Declares lock, then counts bit errors and errored words against a free-running local replica.
- Sits at the sink end of BIST/loopback datapaths; status and counters are read by control logic.

Parameters:
POL_MASK  8'hC0  tap mask applied to each (POL_W+1)-bit window, same convention as the generator
POL_W  7  PN state width
DW  16  word width
LOCK_CNT  4  consecutive clean, non-zero-seed words needed to lock
UNLOCK_CNT  4  consecutive errored words while locked that force re-search
CNT_W  32  width of error and word counters

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of counters and sticky flag; lock state unaffected
data_valid  input  1  data_in qualifier
data_in  input  DW  received word; bit DW-1 oldest, bit 0 newest (generator ordering)
locked  output  1  checker locked to sequence
err_word  output  1  one-cycle pulse: last valid word had >=1 bit error while locked
err_sticky  output  1  set on any err_word, cleared by clear or reset
bit_err_cnt  output  CNT_W  saturating count of bit errors while locked
word_cnt  output  CNT_W  saturating count of valid words checked while locked

Behaviour:
- Expected word from state S (POL_W bits): full = {S, exp}; exp[i] = ^(full[i +: POL_W+1] & POL_MASK), i = 0..DW-1, same recurrence as generator. Next-state source = a word's bits [POL_W-1:0].
- Reset (rst_n low, async): state=SEARCH, S=0, locked=0, err_word=0, err_sticky=0, both counters 0, lock/unlock counters 0.
- Idle: no state, counter or S change on cycles with data_valid=0; err_word deasserts.
- SEARCH, each valid word:
  - compare data_in with exp(S); clean = no mismatch AND S != 0 (all-zero seed never counts; all-zero input cannot lock).
  - clean -> lock_ctr++; otherwise lock_ctr=0.
  - S <= data_in[POL_W-1:0] (self-sync, reload from received data).
  - lock_ctr reaches LOCK_CNT -> state=LOCKED, locked=1 next cycle, unlock_ctr=0.
- LOCKED, each valid word:
  - mismatch = data_in ^ exp(S); nbits = popcount(mismatch), width $clog2(DW+1).
  - S <= exp(S)[POL_W-1:0] (free-running replica; single bit errors not multiplied).
  - word_cnt += 1; bit_err_cnt += nbits; both saturate at all-ones, no wrap.
  - nbits != 0 -> err_word=1 for one cycle, err_sticky=1, unlock_ctr++; nbits == 0 -> unlock_ctr=0.
  - unlock_ctr reaches UNLOCK_CNT -> state=SEARCH, locked=0 next cycle, lock_ctr=0, S <= data_in[POL_W-1:0].
- Latency: all outputs registered; updates visible one cycle after the valid word is sampled.
- clear together with data_valid: clear wins; the word is still checked for lock/unlock, but its counts and sticky are discarded.
- Reset mid-stream: immediate return to reset values; resync needs LOCK_CNT+1 valid words.

Optional Feature:
- Macro PRBS_CHK_INVERT_EN.
- Defined: data_in is bitwise inverted at the input before any comparison or seeding, for links that transmit inverted PN.
- Undefined: data_in is used as-is.
- Counters, lock rules and latency are identical in both builds.

Test Plan:
- Generator model, seed 7'h7F, continuous valid -> locked=1 on cycle after 5th valid word; bit_err_cnt=0; word_cnt=N-5 after N words.
- Locked, flip bit 3 of one word -> err_word one pulse, bit_err_cnt=1 (not 3), err_sticky=1, locked stays 1.
- Locked, inject 4 consecutive words with errors -> locked=0 after 4th; clean stream resumes -> relock after 5 words.
- Constant data_in=16'h0000 for 100 words -> locked never asserts, counters stay 0.
- Counter saturation (CNT_W=4 override), every word 16'hFFFF-corrupted after lock -> bit_err_cnt holds 4'hF; clear -> 0 next cycle, err_sticky=0.
- rst_n low asynchronously mid-word while locked -> all outputs 0 without clock edge; gaps of data_valid=0 between words -> no effect on lock timing.
